// File: rtl/uart_frame_loader_if.sv
// Byte-stream bus from the frame loader to the logic-gate-network core.
// The master presents a byte with valid/first/last; the slave accepts it with ready.
interface uart_frame_loader_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_first;
    logic       out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_first,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_first,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/uart_frame_loader.sv
// 8N1 UART receiver plus frame buffer: waits for a sync byte, captures FRAME_BYTES
// payload bytes, then streams them to the core over a valid/ready byte bus.
module uart_frame_loader #(
    parameter int unsigned CLK_HZ      = 12000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FRAME_BYTES = 98,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       uart_rx,
    uart_frame_loader_if.master        out_if,
    output logic                       frame_done,
    output logic                       frame_err,
    output logic                       overrun
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned PW           = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(FRAME_BYTES - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_STREAM    = 2'd2;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_strobe_q, rx_strobe_d;
    logic          rx_ferr_q, rx_ferr_d;

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          mem_we;
    logic [7:0]    mem_q [FRAME_BYTES];

    logic          streaming;
    logic          handshake;

    // Two-flop synchronizer; idles high so reset does not look like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // A start requires a high-to-low transition, so after a bad stop bit the
    // receiver naturally waits for the line to return high first.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_strobe_d = 1'b0;
        rx_ferr_d   = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        rx_strobe_d = 1'b1;
                        rx_byte_d   = rx_shift_q;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_strobe_q <= 1'b0;
            rx_ferr_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_strobe_q <= rx_strobe_d;
            rx_ferr_q   <= rx_ferr_d;
        end
    end

    assign streaming = (state_q == ST_STREAM);
    assign handshake = streaming && out_if.out_ready;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = overrun_q;
        mem_we       = 1'b0;
        unique case (state_q)
            ST_WAIT_SYNC: begin
                if (rx_strobe_q && (rx_byte_q == SYNC_BYTE)) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                end
            end
            ST_LOAD: begin
                if (rx_ferr_q) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_WAIT_SYNC;
                    wr_ptr_d    = '0;
                end else if (rx_strobe_q) begin
                    mem_we = 1'b1;
                    if (wr_ptr_q == LAST_IDX) begin
                        state_d  = ST_STREAM;
                        rd_ptr_d = '0;
                        wr_ptr_d = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                // Bytes landing here, even on the final handshake, are overruns.
                if (rx_strobe_q) begin
                    overrun_d = 1'b1;
                end
                if (handshake) begin
                    if (rd_ptr_q == LAST_IDX) begin
                        state_d      = ST_WAIT_SYNC;
                        rd_ptr_d     = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_WAIT_SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_WAIT_SYNC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Frame storage carries no reset; contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= rx_byte_q;
        end
    end

    always_comb begin
        out_if.out_valid = streaming;
        out_if.out_data  = streaming ? mem_q[rd_ptr_q] : 8'h00;
        out_if.out_first = streaming && (rd_ptr_q == '0);
        out_if.out_last  = streaming && (rd_ptr_q == LAST_IDX);
    end

    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: directed UART frames in, byte stream checked
// by an independent monitor against expected entries queued as stimulus is sent.
module tb_uart_frame_loader;

    localparam int unsigned CLK_HZ = 921600;
    localparam int unsigned BAUD   = 115200;
    localparam int unsigned CPB    = CLK_HZ / BAUD;
    localparam int unsigned FB     = 98;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_rx = 1'b1;
    logic rdy = 1'b0;
    logic frame_done, frame_err, overrun;

    uart_frame_loader_if out_bus ();
    assign out_bus.out_ready = rdy;

    uart_frame_loader #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .FRAME_BYTES (FB),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .out_if     (out_bus.master),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q [$];  // {data, first, last}
    int ready_mode = 0;
    int ready_cnt  = 0;
    int done_cnt   = 0;
    int ferr_cnt   = 0;
    int stall_cnt  = 0;
    bit done_expect = 1'b0;
    bit stall_q = 1'b0;
    logic [9:0] prev_q = '0;
    logic [9:0] cur;
    logic [9:0] e;
    logic [7:0] pl [FB];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Mode 0: always ready; 1: repeating 1,0,0,1; 2: never ready.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: rdy = 1'b1;
            1: begin
                rdy = ((ready_cnt % 4) == 0) || ((ready_cnt % 4) == 3);
                ready_cnt++;
            end
            default: rdy = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        cur = {out_bus.out_data, out_bus.out_first, out_bus.out_last};
        if (rst) begin
            stall_q     = 1'b0;
            done_expect = 1'b0;
        end else begin
            if (frame_err) ferr_cnt++;
            if (done_expect) begin
                check("frame_done_pulse", {31'd0, frame_done}, 32'd1);
                check("valid_after_last", {31'd0, out_bus.out_valid}, 32'd0);
                done_expect = 1'b0;
                done_cnt++;
            end else if (frame_done) begin
                check("spurious_frame_done", {31'd0, frame_done}, 32'd0);
            end
            if (stall_q) begin
                stall_cnt++;
                check("hold_during_stall", {22'd0, cur}, {22'd0, prev_q});
            end
            if (out_bus.out_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h required no output", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_byte", {22'd0, cur}, {22'd0, e});
                    if (e[0]) done_expect = 1'b1;
                end
            end
            stall_q = out_bus.out_valid && !rdy;
            prev_q  = cur;
        end
    end

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(good_stop);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame_push();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < FB; i++) begin
            exp_q.push_back({pl[i], 1'(i == 0), 1'(i == FB - 1)});
            send_byte(pl[i], 1'b1);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || done_expect) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, {31'd0, (n >= 5000)}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, out_bus.out_valid}, 32'd0);
        check("rst_data", {24'd0, out_bus.out_data}, 32'd0);
        check("rst_first_last", {30'd0, out_bus.out_first, out_bus.out_last}, 32'd0);
        check("rst_pulses", {30'd0, frame_done, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Ascending payload, core always ready.
        for (int i = 0; i < FB; i++) pl[i] = 8'(i);
        send_frame_push();
        drain("t1_drain");
        check("t1_done_cnt", done_cnt, 1);
        check("t1_ferr_cnt", ferr_cnt, 0);
        check("t1_overrun", {31'd0, overrun}, 32'd0);

        // Leading junk before sync is ignored.
        for (int i = 0; i < FB; i++) pl[i] = 8'hFF;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_frame_push();
        drain("t2_drain");
        check("t2_done_cnt", done_cnt, 2);

        // Same frame with the core stalling.
        ready_cnt  = 0;
        ready_mode = 1;
        send_frame_push();
        drain("t3_drain");
        ready_mode = 0;
        check("t3_done_cnt", done_cnt, 3);
        check("t3_stalls_seen", {31'd0, (stall_cnt > 0)}, 32'd1);

        // Framing error mid-load aborts the frame.
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 10; i++) send_byte(8'(i + 8'h40), 1'b1);
        send_byte(8'h77, 1'b0);
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("t4_ferr_cnt", ferr_cnt, 1);
        check("t4_no_valid", {31'd0, out_bus.out_valid}, 32'd0);

        // Full frame after the abort, held by the core, then an overrun byte.
        for (int i = 0; i < FB; i++) pl[i] = 8'(i) ^ 8'h5A;
        ready_mode = 2;
        send_frame_push();
        repeat (5) @(posedge clk);
        #1;
        check("t5_valid_held", {31'd0, out_bus.out_valid}, 32'd1);
        check("t5_first_byte", {22'd0, out_bus.out_data, out_bus.out_first, out_bus.out_last},
              {22'd0, 8'h5A, 1'b1, 1'b0});
        send_byte(8'h55, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t5_overrun_set", {31'd0, overrun}, 32'd1);
        ready_mode = 0;
        drain("t5_drain");
        check("t5_done_cnt", done_cnt, 4);
        check("t5_overrun_sticky", {31'd0, overrun}, 32'd1);
        check("t5_ferr_cnt", ferr_cnt, 1);

        // Short low glitch inside a payload must not insert a byte.
        for (int i = 0; i < FB; i++) pl[i] = 8'(8'hC0 - i);
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < FB; i++) begin
            exp_q.push_back({pl[i], 1'(i == 0), 1'(i == FB - 1)});
            send_byte(pl[i], 1'b1);
            if (i == 48) begin
                uart_rx = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                uart_rx = 1'b1;
                repeat (2 * CPB) @(posedge clk);
                #1;
            end
        end
        drain("t6_glitch_drain");
        check("t6_done_cnt", done_cnt, 5);

        // Reset mid-load discards the partial frame and clears overrun.
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 50; i++) send_byte(8'(i), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_valid", {31'd0, out_bus.out_valid}, 32'd0);
        check("rst2_data", {24'd0, out_bus.out_data}, 32'd0);
        check("rst2_first_last", {30'd0, out_bus.out_first, out_bus.out_last}, 32'd0);
        check("rst2_pulses", {30'd0, frame_done, frame_err}, 32'd0);
        check("rst2_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 48; i++) send_byte(8'h00, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        check("rst2_no_resume", {31'd0, out_bus.out_valid}, 32'd0);
        check("rst2_done_cnt", done_cnt, 5);
        check("rst2_ferr_cnt", ferr_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
- Upstream input stage for the MNIST logic-gate-network core on the FPGA board.
- Receives a 28x28 binary image as packed bytes over UART (8N1), framed by a sync byte, and buffers the whole frame.
- Streams the frame to the core's 8-bit input bus with a valid/ready handshake, marking the first and last bytes.
- Replaces the button-driven stimulus at the top level.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_HZ/BAUD, truncated (104 at defaults).
- FRAME_BYTES, 98, payload bytes per frame (784 pixels / 8).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- uart_rx  in  1  serial input, idle high, asynchronous to clk.
- out_data  out  8  frame byte presented to the core.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  core accepts the byte this cycle.
- out_first  out  1  high with byte 0 of the frame.
- out_last  out  1  high with byte FRAME_BYTES-1.
- frame_done  out  1  one-cycle pulse after the last byte is accepted.
- frame_err  out  1  one-cycle pulse on framing error or frame abort.
- overrun  out  1  sticky flag; set when a byte arrives during STREAM; cleared only by rst.

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM in WAIT_SYNC; pointers 0; receiver idle. Buffer contents are don't-care.

UART receiver:
- uart_rx passes through a 2-FF synchronizer; the sync chain resets to 1.
- IDLE: a synchronized falling edge starts a START phase.
- START: at CLKS_PER_BIT/2 cycles, sample the line. If it is high, treat it as a glitch and return to IDLE with no error.
- DATA: sample 8 bits, LSB first, every CLKS_PER_BIT cycles.
- STOP: sample the stop bit one CLKS_PER_BIT later.
  - Stop bit high: emit an internal rx_strobe with the byte for one cycle.
  - Stop bit low: raise an internal rx_ferr for one cycle and drop the byte.
- In all cases the receiver returns to IDLE and waits for the line to be high before accepting a new start edge.

Frame FSM:
- WAIT_SYNC:
  - rx_strobe with byte==SYNC_BYTE: go to LOAD, wr_ptr=0.
  - Any other byte: discard.
  - rx_ferr: ignored, no frame_err pulse.
- LOAD:
  - rx_strobe: buf[wr_ptr]=byte, wr_ptr+1.
  - On writing index FRAME_BYTES-1: go to STREAM, rd_ptr=0.
  - rx_ferr: pulse frame_err, go to WAIT_SYNC, discard the partial frame.
  - A SYNC_BYTE value inside the payload is stored as ordinary data and does not resync.
- STREAM:
  - out_valid=1 starting the first cycle in STREAM.
  - out_data=buf[rd_ptr]; out_first=(rd_ptr==0); out_last=(rd_ptr==FRAME_BYTES-1).
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - out_valid&&out_ready advances rd_ptr, allowing one byte per cycle with out_ready held high.
  - Acceptance of the last byte: next cycle out_valid=0 and frame_done=1 for one cycle; FSM returns to WAIT_SYNC.
  - rx_strobe in STREAM: byte dropped, overrun set. rx_ferr in STREAM: ignored.
- Minimum latency: from the stop-bit sample of the final payload byte to out_valid=1 is 2 cycles.
- Simultaneous events:
  - rx_strobe in the same cycle as the final STREAM handshake counts as an overrun. That byte is not a sync candidate.
- Reset mid-frame: everything is discarded immediately; no frame_done pulse and no frame_err pulse.
- Pointer widths: $clog2(FRAME_BYTES); pointers never wrap past FRAME_BYTES-1.

Test Plan:
- Default parameters. Send 0xA5 then bytes 0x00..0x61 at 115200 baud, out_ready=1.
  -> 98 consecutive valid cycles with out_data 0x00..0x61; out_first on 0x00; out_last on 0x61; frame_done one cycle after; frame_err=0; overrun=0.
- Send 0x12, 0x34, then 0xA5 plus 98 bytes of 0xFF.
  -> The leading two bytes are ignored; exactly 98 bytes of 0xFF are output.
- Same frame, with out_ready toggling 1,0,0,1 repeatedly.
  -> out_data, out_first and out_last are held during the stalls; all 98 bytes are delivered in order, with no duplicates or skips.
- Send 0xA5 and 10 payload bytes, then a byte with its stop bit driven low.
  -> frame_err pulses once; no out_valid. Then send a full valid frame -> it streams correctly.
- Hold out_ready=0 after a frame loads, and send 0x55.
  -> overrun=1 and stays set; the streamed frame is unchanged. Asserting rst clears overrun.
- Drive a 20-cycle low glitch on uart_rx, then assert rst mid-LOAD after 50 bytes.
  -> The glitch produces no byte. During rst all outputs are 0; afterwards the FSM waits for a new SYNC_BYTE.
